affine_addr_decoder: RTL
========================

// Module: affine_addr_decoder
// PURPOSE
//  Receiving end of the 2-D affine address stream addr = offset + x*x_stride + y*y_stride.
//  Accepts one address per valid/ready beat and recovers its (x, y) coordinate.
//  Flags any address that departs from the programmed scan order.
//  Sits between the scan address generator and the memory or bank logic that needs coordinates.
// PARAMETERS
//  ADDR_W  32  width of addresses, strides, offset, extents and coordinates
// PORTS
//  clk           in   1       single clock, rising edge
//  rst_n         in   1       asynchronous, active-low reset
//  start         in   1       1-cycle pulse; latches cfg_* and begins a frame
//  cfg_offset    in   ADDR_W  base address
//  cfg_x_max     in   ADDR_W  x extent; valid coordinates are 0..cfg_x_max-1
//  cfg_x_stride  in   ADDR_W  address step per x
//  cfg_y_max     in   ADDR_W  y extent
//  cfg_y_stride  in   ADDR_W  address step per y
//  in_valid      in   1       addr_in valid
//  in_ready      out  1       decoder accepts addr_in this cycle
//  addr_in       in   ADDR_W  incoming address
//  out_valid     out  1       coordinate beat valid
//  out_ready     in   1       downstream accepts beat
//  out_x         out  ADDR_W  x coordinate of the accepted address
//  out_y         out  ADDR_W  y coordinate
//  out_mismatch  out  1       addr_in differed from the expected address
//  out_last      out  1       beat is (x_max-1, y_max-1)
//  busy          out  1       FSM in RUN
//  done          out  1       1-cycle pulse when the last address is accepted
//  cfg_err       out  1       1-cycle pulse when start is rejected
//  err_sticky    out  1       any mismatch since the last start
// BEHAVIOUR
//  Reset: FSM=IDLE; every output is 0; counters, expected address and latched config are 0.
//  States:
//  - IDLE: in_ready=0. On start:
//    - cfg_x_max==0 or cfg_y_max==0 -> pulse cfg_err and stay in IDLE.
//    - Otherwise latch cfg_*, set x=y=0, exp=row_base=cfg_offset, clear err_sticky, go to RUN.
//  - RUN: in_ready = !out_valid | out_ready. start is ignored.
//  Accept = in_valid & in_ready. On accept:
//  - out_{x,y} <= x,y.
//  - out_mismatch <= (addr_in != exp).
//  - out_last <= (x==x_max-1 & y==y_max-1).
//  - out_valid <= 1.
//  - err_sticky |= mismatch.
//  Latency is 1 cycle from accept to out_valid.
//  Advance on accept (incremental; no multipliers):
//  - x<x_max-1: x++, exp += x_stride.
//  - x==x_max-1, not last: x=0, y++, row_base += y_stride, exp = row_base + y_stride.
//  - last: pulse done, go to IDLE. Counters are not reset until the next start.
//  Output register:
//  - out_valid clears on out_ready when there is no accept in the same cycle.
//  - Drain and accept in the same cycle overwrite the register with no bubble.
//  - Held beats are stable until out_ready.
//  - A pending last beat survives the return to IDLE and a new start.
//  Mismatch does not resync: the decoder always reports the scheduled coordinate.
//  Arithmetic is unsigned modulo 2^ADDR_W; address wrap-around is legal and not an error.
//  x_max==1 is legal: every accept increments y. x_max==1 and y_max==1 gives a 1-beat frame.
//  rst_n assertion mid-frame: immediate return to the reset state; the in-flight beat is lost.
// STRUCTURE
//  Package frail_scan_pkg:
//  - addr_t (logic [ADDR_W-1:0]).
//  - dec_state_e {IDLE, RUN}.
//  - struct coord_t {x, y, mismatch, last}.
//  Sub-module affine_scan_counter owns:
//  - the x/y counters, row_base and exp;
//  - ports step, load, is_last.
//  The top level holds the FSM, the handshake and the output register.
// TESTING
//  1. Offset 100, x_max 3, x_stride 4, y_max 2, y_stride 16; feed 100,104,108,116,120,124.
//     -> (0,0)..(2,1), no mismatch, out_last on beat 6, done pulse, back to IDLE.
//  2. Same config, 3rd address 109.
//     -> beat 3 out_mismatch=1 at coordinate (2,0); err_sticky=1 until the next start.
//  3. out_ready held low 5 cycles mid-frame.
//     -> in_ready=0 after one beat is buffered; no beat is lost or duplicated.
//     -> Then in_valid=out_ready=1 sustains one beat per cycle.
//  4. start with cfg_y_max=0.
//     -> cfg_err pulse, busy stays 0, in_ready stays 0.
//  5. offset 32'hFFFF_FFF8, x_stride 8, x_max 2, y_max 1.
//     -> expected addresses are FFFF_FFF8 then 0; both accepted without mismatch.
//  6. rst_n low for 1 cycle after beat 2, then a new start.
//     -> all outputs are 0 during reset; the next frame starts at (0,0).

Source files
------------

// File: rtl/affine_addr_decoder_pkg.sv
// frail_scan_pkg: shared types for the affine address decoder
//  addr_t      address/coordinate word
//  dec_state_e decoder FSM states
//  coord_t     one decoded output beat
package frail_scan_pkg;
  localparam int ADDR_WIDTH = 32;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef enum logic {IDLE, RUN} dec_state_e;
  typedef struct packed {
    addr_t x;
    addr_t y;
    logic  mismatch;
    logic  last;
  } coord_t;
endpackage

// File: rtl/affine_addr_decoder_scan_counter.sv
// affine_scan_counter: tracks the scheduled (x, y) and expected address of the scan
//  clk, rst_n   clock, async active-low reset
//  load         latch cfg_* and restart at (0,0) with exp = row_base = cfg_offset
//  step         advance to the next scheduled coordinate
//  cfg_*        frame configuration
//  x, y         current scheduled coordinate
//  exp_addr     address expected at (x, y)
//  is_last      (x, y) is the final coordinate of the frame
module affine_scan_counter
  import frail_scan_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  step,
  input  logic [ADDR_WIDTH-1:0] cfg_offset,
  input  logic [ADDR_WIDTH-1:0] cfg_x_max,
  input  logic [ADDR_WIDTH-1:0] cfg_x_stride,
  input  logic [ADDR_WIDTH-1:0] cfg_y_max,
  input  logic [ADDR_WIDTH-1:0] cfg_y_stride,
  output logic [ADDR_WIDTH-1:0] x,
  output logic [ADDR_WIDTH-1:0] y,
  output logic [ADDR_WIDTH-1:0] exp_addr,
  output logic                  is_last
);
  addr_t r_x, r_y, r_exp, r_row_base, r_x_max, r_x_stride, r_y_max, r_y_stride;
  logic  w_x_end;
  assign w_x_end  = r_x == r_x_max - 1'b1;
  assign is_last  = w_x_end && r_y == r_y_max - 1'b1;
  assign x        = r_x;
  assign y        = r_y;
  assign exp_addr = r_exp;
  // The last step leaves everything in place; only the next load restarts the scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x        <= '0;
      r_y        <= '0;
      r_exp      <= '0;
      r_row_base <= '0;
      r_x_max    <= '0;
      r_x_stride <= '0;
      r_y_max    <= '0;
      r_y_stride <= '0;
    end else if (load) begin
      r_x        <= '0;
      r_y        <= '0;
      r_exp      <= cfg_offset;
      r_row_base <= cfg_offset;
      r_x_max    <= cfg_x_max;
      r_x_stride <= cfg_x_stride;
      r_y_max    <= cfg_y_max;
      r_y_stride <= cfg_y_stride;
    end else if (step && !is_last) begin
      r_x        <= w_x_end ? '0 : r_x + 1'b1;
      r_y        <= w_x_end ? r_y + 1'b1 : r_y;
      r_row_base <= w_x_end ? r_row_base + r_y_stride : r_row_base;
      r_exp      <= w_x_end ? r_row_base + r_y_stride : r_exp + r_x_stride;
    end
  end
endmodule

// File: rtl/affine_addr_decoder.sv
// affine_addr_decoder: recovers (x, y) from an affine address stream and flags out-of-order addresses
//  clk, rst_n               clock, async active-low reset
//  start, cfg_*             frame start pulse and configuration
//  in_valid/in_ready/addr_in   address input handshake
//  out_valid/out_ready      coordinate output handshake
//  out_x/out_y/out_mismatch/out_last   decoded beat
//  busy, done, cfg_err, err_sticky     status
module affine_addr_decoder
  import frail_scan_pkg::*;
#(
  parameter int ADDR_W = ADDR_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_offset,
  input  logic [ADDR_W-1:0] cfg_x_max,
  input  logic [ADDR_W-1:0] cfg_x_stride,
  input  logic [ADDR_W-1:0] cfg_y_max,
  input  logic [ADDR_W-1:0] cfg_y_stride,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] addr_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_x,
  output logic [ADDR_W-1:0] out_y,
  output logic              out_mismatch,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic              err_sticky
);
  dec_state_e r_state, w_next;
  coord_t     r_out;
  logic       r_out_valid, r_done, r_cfg_err, r_err_sticky;
  addr_t      w_x, w_y, w_exp;
  logic       w_is_last, w_accept, w_load, w_bad_cfg, w_mismatch;
  assign w_bad_cfg  = cfg_x_max == '0 || cfg_y_max == '0;
  assign w_load     = r_state == IDLE && start && !w_bad_cfg;
  // The output register may be refilled in the same cycle it drains.
  assign in_ready   = r_state == RUN && (!r_out_valid || out_ready);
  assign w_accept   = in_valid && in_ready;
  assign w_mismatch = addr_in != w_exp;
  affine_scan_counter u_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (w_load),
    .step        (w_accept),
    .cfg_offset  (cfg_offset),
    .cfg_x_max   (cfg_x_max),
    .cfg_x_stride(cfg_x_stride),
    .cfg_y_max   (cfg_y_max),
    .cfg_y_stride(cfg_y_stride),
    .x           (w_x),
    .y           (w_y),
    .exp_addr    (w_exp),
    .is_last     (w_is_last)
  );
  always_comb begin
    w_next = r_state;
    if (w_load) w_next = RUN;
    else if (w_accept && w_is_last) w_next = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out        <= '0;
      r_out_valid  <= 1'b0;
      r_done       <= 1'b0;
      r_cfg_err    <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      r_done       <= w_accept && w_is_last;
      r_cfg_err    <= r_state == IDLE && start && w_bad_cfg;
      r_err_sticky <= !w_load && (r_err_sticky || (w_accept && w_mismatch));
      if (w_accept) begin
        r_out       <= '{x: w_x, y: w_y, mismatch: w_mismatch, last: w_is_last};
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end
  assign out_valid    = r_out_valid;
  assign out_x        = r_out.x;
  assign out_y        = r_out.y;
  assign out_mismatch = r_out.mismatch;
  assign out_last     = r_out.last;
  assign busy         = r_state == RUN;
  assign done         = r_done;
  assign cfg_err      = r_cfg_err;
  assign err_sticky   = r_err_sticky;
endmodule
